// File: rtl/ddr_pkg.sv
// ddr_pkg: command/state encodings and default sizing shared by the DDR
// request arbiter and its refresh timer.
package ddr_pkg;

    localparam int DDR_ADDR_W           = 25;   // bank 2 + row 13 + column 10
    localparam int DDR_REFRESH_INTERVAL = 1040; // 7.8 us at 133 MHz
    localparam int DDR_MAX_VID_RUN      = 8;
    localparam int DDR_DATA_W           = 16;

    typedef enum logic [1:0] {
        CMD_READ    = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_REFRESH = 2'b10
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } arb_state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// ddr_refresh_timer: free-running auto-refresh interval counter with a
// pending flag (set on expiry, cleared when the refresh is accepted) and a
// sticky overrun flag for an interval that expires while still pending.
module ddr_refresh_timer
    import ddr_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DDR_REFRESH_INTERVAL
) (
    input  logic clk133,
    input  logic rst_n,
    input  logic enable,
    input  logic pending_clr,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    // Count down while enabled; an expiry coinciding with a clear starts a new
    // interval rather than counting as an overrun.
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (!enable) begin
            count_d = RELOAD;
        end else if (count_q == '0) begin
            count_d = RELOAD;
            expire  = 1'b1;
        end else begin
            count_d = count_q - CNT_W'(1);
        end
        pending_d = (pending_q & ~pending_clr) | expire;
        overrun_d = overrun_q | (expire & pending_q & ~pending_clr);
    end

    // Timer and flag registers.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/ddr_request_arbiter.sv
// ddr_request_arbiter: single-port DDR access arbiter between the video
// scan-out reader and the drawing-engine writer, with periodic auto-refresh.
// One command in flight: IDLE (arbitrate) -> ISSUE (valid/ready) ->
// WAIT_DONE (until memDone).
// Optional build macro DDR_ARB_STATS_EN adds saturating grant/refresh
// counters and a synchronous statsClear input.
module ddr_request_arbiter
    import ddr_pkg::*;
#(
    parameter int ADDR_W           = DDR_ADDR_W,
    parameter int REFRESH_INTERVAL = DDR_REFRESH_INTERVAL,
    parameter int MAX_VID_RUN      = DDR_MAX_VID_RUN
) (
    input  logic              clk133,
    input  logic              rst_n,
    input  logic              initDone,
    input  logic              vidReq,
    input  logic [ADDR_W-1:0] vidAddr,
    output logic              vidGnt,
    input  logic              drawReq,
    input  logic [ADDR_W-1:0] drawAddr,
    input  logic [15:0]       drawData,
    output logic              drawGnt,
    output logic              memCmdValid,
    output logic [1:0]        memCmdKind,
    output logic [ADDR_W-1:0] memCmdAddr,
    output logic [15:0]       memCmdData,
    input  logic              memCmdReady,
    input  logic              memDone,
    output logic              refreshOverrun
`ifdef DDR_ARB_STATS_EN
    ,
    input  logic              statsClear,
    output logic [15:0]       vidGrantCount,
    output logic [15:0]       drawGrantCount,
    output logic [15:0]       refreshCount
`endif
);

    localparam int RUN_W = $clog2(MAX_VID_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

    arb_state_e        state_q, state_d;
    cmd_kind_e         cmd_kind_q, cmd_kind_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [15:0]       cmd_data_q, cmd_data_d;
    logic              vid_gnt_q, vid_gnt_d;
    logic              draw_gnt_q, draw_gnt_d;
    logic [RUN_W-1:0]  vid_run_q, vid_run_d;

    logic              refresh_pending;
    logic              refresh_overrun;
    logic              refresh_clr;
    logic              accept;
    logic              win_valid;
    cmd_kind_e         win_kind;
    logic              take_win;

    assign accept      = (state_q == ST_ISSUE) && memCmdReady;
    assign refresh_clr = accept && (cmd_kind_q == CMD_REFRESH);
    assign take_win    = (state_q == ST_IDLE) && initDone && win_valid;

    ddr_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk133      (clk133),
        .rst_n       (rst_n),
        .enable      (initDone),
        .pending_clr (refresh_clr),
        .pending     (refresh_pending),
        .overrun     (refresh_overrun)
    );

    // Fixed-priority pick: refresh, starved draw, video, draw.
    always_comb begin
        win_valid = 1'b1;
        win_kind  = CMD_READ;
        if (refresh_pending) begin
            win_kind = CMD_REFRESH;
        end else if (drawReq && (vid_run_q == RUN_MAX)) begin
            win_kind = CMD_WRITE;
        end else if (vidReq) begin
            win_kind = CMD_READ;
        end else if (drawReq) begin
            win_kind = CMD_WRITE;
        end else begin
            win_valid = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; memDone outside WAIT_DONE has no effect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (initDone && win_valid) state_d = ST_ISSUE;
            ST_ISSUE:     if (memCmdReady)           state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (memDone)               state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // Command latch, grant pulses and video run-length tracking.
    always_comb begin
        cmd_kind_d = cmd_kind_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        vid_run_d  = vid_run_q;
        vid_gnt_d  = accept && (cmd_kind_q == CMD_READ);
        draw_gnt_d = accept && (cmd_kind_q == CMD_WRITE);

        if (take_win) begin
            cmd_kind_d = win_kind;
            case (win_kind)
                CMD_READ: begin
                    cmd_addr_d = vidAddr;
                    cmd_data_d = '0;
                end
                CMD_WRITE: begin
                    cmd_addr_d = drawAddr;
                    cmd_data_d = drawData;
                end
                default: begin
                    cmd_addr_d = '0;
                    cmd_data_d = '0;
                end
            endcase
        end

        if (accept) begin
            if (cmd_kind_q == CMD_WRITE) begin
                vid_run_d = '0;
            end else if (cmd_kind_q == CMD_READ) begin
                if (!drawReq) begin
                    vid_run_d = '0;
                end else if (vid_run_q != RUN_MAX) begin
                    vid_run_d = vid_run_q + RUN_W'(1);
                end
            end
        end
    end

    // Command and grant registers.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            cmd_kind_q <= CMD_READ;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            vid_gnt_q  <= 1'b0;
            draw_gnt_q <= 1'b0;
            vid_run_q  <= '0;
        end else begin
            cmd_kind_q <= cmd_kind_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            vid_gnt_q  <= vid_gnt_d;
            draw_gnt_q <= draw_gnt_d;
            vid_run_q  <= vid_run_d;
        end
    end

    // FSM outputs: valid is a decode of the registered state.
    always_comb begin
        memCmdValid    = (state_q == ST_ISSUE);
        memCmdKind     = cmd_kind_q;
        memCmdAddr     = cmd_addr_q;
        memCmdData     = cmd_data_q;
        vidGnt         = vid_gnt_q;
        drawGnt        = draw_gnt_q;
        refreshOverrun = refresh_overrun;
    end

`ifdef DDR_ARB_STATS_EN
    logic [15:0] vid_cnt_q, vid_cnt_d;
    logic [15:0] draw_cnt_q, draw_cnt_d;
    logic [15:0] ref_cnt_q, ref_cnt_d;

    // Count accepted commands; a clear wins over a same-cycle increment.
    always_comb begin
        vid_cnt_d  = vid_cnt_q;
        draw_cnt_d = draw_cnt_q;
        ref_cnt_d  = ref_cnt_q;
        if (statsClear) begin
            vid_cnt_d  = '0;
            draw_cnt_d = '0;
            ref_cnt_d  = '0;
        end else begin
            if (vid_gnt_d)   vid_cnt_d  = sat_inc16(vid_cnt_q);
            if (draw_gnt_d)  draw_cnt_d = sat_inc16(draw_cnt_q);
            if (refresh_clr) ref_cnt_d  = sat_inc16(ref_cnt_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            vid_cnt_q  <= '0;
            draw_cnt_q <= '0;
            ref_cnt_q  <= '0;
        end else begin
            vid_cnt_q  <= vid_cnt_d;
            draw_cnt_q <= draw_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
        end
    end

    assign vidGrantCount  = vid_cnt_q;
    assign drawGrantCount = draw_cnt_q;
    assign refreshCount   = ref_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// tb_ddr_request_arbiter: directed table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ddr_request_arbiter;

    localparam int AW      = 25;
    localparam int REF_INT = 1040;
    localparam int MAX_RUN = 8;

    localparam logic [AW-1:0] VADDR = 25'h0012345;
    localparam logic [AW-1:0] DADDR = 25'h1ABCDEF;
    localparam logic [15:0]   DDATA = 16'hBEEF;

    logic          clk133 = 1'b0;
    logic          rst_n;
    logic          initDone;
    logic          vidReq;
    logic [AW-1:0] vidAddr;
    logic          vidGnt;
    logic          drawReq;
    logic [AW-1:0] drawAddr;
    logic [15:0]   drawData;
    logic          drawGnt;
    logic          memCmdValid;
    logic [1:0]    memCmdKind;
    logic [AW-1:0] memCmdAddr;
    logic [15:0]   memCmdData;
    logic          memCmdReady;
    logic          memDone;
    logic          refreshOverrun;
`ifdef DDR_ARB_STATS_EN
    logic          statsClear = 1'b0;
    logic [15:0]   vidGrantCount, drawGrantCount, refreshCount;
`endif

    always #5 clk133 = ~clk133;

    ddr_request_arbiter dut (
        .clk133         (clk133),
        .rst_n          (rst_n),
        .initDone       (initDone),
        .vidReq         (vidReq),
        .vidAddr        (vidAddr),
        .vidGnt         (vidGnt),
        .drawReq        (drawReq),
        .drawAddr       (drawAddr),
        .drawData       (drawData),
        .drawGnt        (drawGnt),
        .memCmdValid    (memCmdValid),
        .memCmdKind     (memCmdKind),
        .memCmdAddr     (memCmdAddr),
        .memCmdData     (memCmdData),
        .memCmdReady    (memCmdReady),
        .memDone        (memDone),
        .refreshOverrun (refreshOverrun)
`ifdef DDR_ARB_STATS_EN
        ,
        .statsClear     (statsClear),
        .vidGrantCount  (vidGrantCount),
        .drawGrantCount (drawGrantCount),
        .refreshCount   (refreshCount)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model thinks in transactions: a command is "free", "offered" to the
    // sequencer or "busy" in it; refresh deadlines come from the count of
    // initDone-high edges being a multiple of the interval.
    localparam int PH_FREE = 0, PH_OFFER = 1, PH_BUSY = 2;
    bit          model_on = 0;
    int unsigned m_edges;
    int          m_phase, m_run;
    bit          m_pend, m_ovr, m_vg, m_dg;
    logic [1:0]  m_kind;
    logic [AW-1:0] m_addr;
    logic [15:0] m_data;

    function automatic void model_reset();
        m_edges = 0; m_phase = PH_FREE; m_run = 0;
        m_pend = 0; m_ovr = 0; m_vg = 0; m_dg = 0;
        m_kind = 2'b00; m_addr = '0; m_data = '0;
    endfunction

    function automatic void model_step();
        bit expire, accepted, clr, old_pend;
        int old_run;
        expire = 0;
        if (initDone) begin
            m_edges++;
            expire = (m_edges % REF_INT) == 0;
        end else begin
            m_edges = 0;
        end
        old_pend = m_pend;
        old_run  = m_run;
        accepted = (m_phase == PH_OFFER) && memCmdReady;
        clr      = accepted && (m_kind == 2'b10);
        m_vg     = accepted && (m_kind == 2'b00);
        m_dg     = accepted && (m_kind == 2'b01);
        if (m_vg) m_run = drawReq ? ((old_run < MAX_RUN) ? old_run + 1 : MAX_RUN) : 0;
        if (m_dg) m_run = 0;
        m_ovr  = m_ovr | (expire && old_pend && !clr);
        m_pend = (old_pend && !clr) || expire;
        case (m_phase)
            PH_FREE: if (initDone) begin
                if (old_pend) begin
                    m_kind = 2'b10; m_addr = '0; m_data = '0; m_phase = PH_OFFER;
                end else if (drawReq && old_run == MAX_RUN) begin
                    m_kind = 2'b01; m_addr = drawAddr; m_data = drawData; m_phase = PH_OFFER;
                end else if (vidReq) begin
                    m_kind = 2'b00; m_addr = vidAddr; m_data = '0; m_phase = PH_OFFER;
                end else if (drawReq) begin
                    m_kind = 2'b01; m_addr = drawAddr; m_data = drawData; m_phase = PH_OFFER;
                end
            end
            PH_OFFER: if (memCmdReady) m_phase = PH_BUSY;
            default:  if (memDone) m_phase = PH_FREE;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk133);
        if (model_on) model_step();
        #1;
    endtask

    task automatic do_reset(input logic init_after);
        model_on = 0;
        rst_n = 1'b0; initDone = 1'b0;
        vidReq = 1'b0; drawReq = 1'b0; memCmdReady = 1'b0; memDone = 1'b0;
        repeat (2) @(posedge clk133);
        #1;
        model_reset();
        initDone = init_after;
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       vid, drw, rdy, done;
        logic       exp_valid;
        logic [1:0] exp_kind;
        logic       exp_vg, exp_dg;
    } vec_t;
    vec_t vecs [14];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, dcnt, guard;
        logic [AW-1:0] exp_addr;

        vidAddr = VADDR; drawAddr = DADDR; drawData = DDATA;
        rst_n = 1'b0; initDone = 1'b0;
        vidReq = 1'b0; drawReq = 1'b0; memCmdReady = 1'b0; memDone = 1'b0;

        // Reset state
        #12;
        chk("reset valid", memCmdValid, 0);
        chk("reset kind", memCmdKind, 0);
        chk("reset addr", memCmdAddr, 0);
        chk("reset data", memCmdData, 0);
        chk("reset gnts", {vidGnt, drawGnt}, 0);
        chk("reset overrun", refreshOverrun, 0);

        // Table: vid read, draw write, then both requesting.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};

        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            vidReq = vecs[i].vid; drawReq = vecs[i].drw;
            memCmdReady = vecs[i].rdy; memDone = vecs[i].done;
            tick();
            chk($sformatf("vec%0d valid", i), memCmdValid, vecs[i].exp_valid);
            chk($sformatf("vec%0d gnts", i), {vidGnt, drawGnt}, {vecs[i].exp_vg, vecs[i].exp_dg});
            if (vecs[i].exp_valid) begin
                exp_addr = (vecs[i].exp_kind == 2'b01) ? DADDR : VADDR;
                chk($sformatf("vec%0d cmd", i), {memCmdKind, memCmdAddr, memCmdData},
                    {vecs[i].exp_kind, exp_addr, (vecs[i].exp_kind == 2'b01) ? DDATA : 16'h0});
            end
        end

        // Both requesters saturated: eight video grants then one draw grant.
        do_reset(1'b1);
        vidReq = 1'b1; drawReq = 1'b1; memCmdReady = 1'b1;
        g = 0; dcnt = -1;
        for (int c = 0; c < 400 && g < 27; c++) begin
            memDone = (dcnt == 0);
            tick();
            if (dcnt >= 0) dcnt--;
            if (vidGnt || drawGnt) begin
                chk($sformatf("pattern grant %0d draw", g), {vidGnt, drawGnt},
                    (g % 9 == 8) ? 2'b01 : 2'b10);
                g++;
                dcnt = 2;
            end
        end
        chk("pattern grant count", g, 27);

        // Refresh expires while a draw is in WAIT_DONE with video waiting.
        do_reset(1'b1);
        repeat (1030) tick();
        drawReq = 1'b1; memCmdReady = 1'b1;
        tick();
        chk("rfw draw issue", {memCmdValid, memCmdKind}, {1'b1, 2'b01});
        tick();
        chk("rfw draw gnt", drawGnt, 1);
        drawReq = 1'b0; vidReq = 1'b1;
        repeat (15) tick();
        chk("rfw waiting", memCmdValid, 0);
        memDone = 1'b1; tick(); memDone = 1'b0;
        tick();
        chk("rfw refresh first", {memCmdValid, memCmdKind, memCmdAddr}, {1'b1, 2'b10, 25'h0});
        tick();
        chk("rfw no vid gnt on refresh", {memCmdValid, vidGnt}, 2'b00);
        memDone = 1'b1; tick(); memDone = 1'b0;
        tick();
        chk("rfw vid after refresh", {memCmdValid, memCmdKind, memCmdAddr}, {1'b1, 2'b00, VADDR});
        tick();
        chk("rfw vid gnt", vidGnt, 1);
        chk("rfw no overrun", refreshOverrun, 0);

        // memDone withheld across two intervals -> sticky overrun.
        do_reset(1'b1);
        vidReq = 1'b1; memCmdReady = 1'b1;
        tick(); tick();
        vidReq = 1'b0;
        repeat (2077) tick();
        chk("overrun before 2nd expiry", refreshOverrun, 0);
        tick();
        chk("overrun at 2nd expiry", refreshOverrun, 1);
        memDone = 1'b1; vidReq = 1'b1;
        repeat (60) tick();
        chk("overrun sticky", refreshOverrun, 1);

        // Reset while a command is being offered.
        memCmdReady = 1'b0;
        guard = 0;
        while (!memCmdValid && guard < 10) begin tick(); guard++; end
        chk("issue reached", memCmdValid, 1);
        memDone = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", {memCmdValid, vidGnt, drawGnt, refreshOverrun}, 4'b0);
        vidReq = 1'b0;
        @(posedge clk133); #1;
        rst_n = 1'b1; initDone = 1'b1;
        repeat (1040) tick();
        chk("refresh not before interval", memCmdValid, 0);
        tick();
        chk("refresh after interval", {memCmdValid, memCmdKind, memCmdAddr, memCmdData},
            {1'b1, 2'b10, 25'h0, 16'h0});
        memCmdReady = 1'b1; tick(); memCmdReady = 1'b0;
        memDone = 1'b1; tick(); memDone = 1'b0;
        repeat (5) tick();
        chk("refresh pending cleared", memCmdValid, 0);

        // Randomized traffic against the model.
        do_reset(1'b0);
        model_on = 1;
        vidAddr = AW'($urandom); drawAddr = AW'($urandom); drawData = 16'($urandom);
        for (int c = 0; c < 6000; c++) begin
            logic [3:0]  act_f, exp_f;
            logic [42:0] act_c, exp_c;
            initDone    = (c >= 30);
            memCmdReady = ($urandom_range(2) != 0);
            memDone     = (m_phase == PH_BUSY) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            tick();
            act_f = {memCmdValid, vidGnt, drawGnt, refreshOverrun};
            exp_f = {m_phase == PH_OFFER, m_vg, m_dg, m_ovr};
            act_c = memCmdValid ? {memCmdKind, memCmdAddr, memCmdData} : 43'h0;
            exp_c = (m_phase == PH_OFFER) ? {m_kind, m_addr, m_data} : 43'h0;
            chk($sformatf("random cyc %0d", c), {act_f, act_c}, {exp_f, exp_c});
            if (vidGnt) vidReq = 1'b0;
            else if (!vidReq && $urandom_range(3) == 0) begin
                vidReq = 1'b1; vidAddr = AW'($urandom);
            end
            if (drawGnt) drawReq = 1'b0;
            else if (!drawReq && $urandom_range(3) == 0) begin
                drawReq = 1'b1; drawAddr = AW'($urandom); drawData = 16'($urandom);
            end
        end
        model_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_request_arbiter.md
Name: ddr_request_arbiter

Overview:
- Arbitrates single-port DDR access between the video scan-out reader (vid) and the drawing-engine writer (draw).
- Also schedules periodic auto-refresh.
- Sits between the requesters and the DDR command sequencer.
- Issues one command at a time (read, write or refresh) over a valid/ready handshake, then waits for the sequencer's completion pulse.

Parameters:
- ADDR_W, 25, DDR word address width: bank 2 + row 13 + column 10.
- REFRESH_INTERVAL, 1040, clk133 cycles between refresh requests (7.8 us at 133 MHz).
- MAX_VID_RUN, 8, consecutive video grants allowed while draw is waiting before draw is forced through.

Ports:
- clk133  in  1  controller clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- initDone  in  1  DDR power-up init complete; arbitration is disabled while low.
- vidReq  in  1  video read request; held with vidAddr until vidGnt.
- vidAddr  in  ADDR_W  video read address.
- vidGnt  out  1  one-cycle pulse: video command accepted by the sequencer.
- drawReq  in  1  draw write request; held with drawAddr and drawData until drawGnt.
- drawAddr  in  ADDR_W  draw write address.
- drawData  in  16  draw write data.
- drawGnt  out  1  one-cycle pulse: draw command accepted.
- memCmdValid  out  1  command valid to the sequencer.
- memCmdKind  out  2  00 read, 01 write, 10 refresh; 11 is never driven.
- memCmdAddr  out  ADDR_W  command address; 0 for refresh.
- memCmdData  out  16  write data; 0 unless the command is a write.
- memCmdReady  in  1  sequencer accepts the command when valid and ready are both high.
- memDone  in  1  one-cycle pulse: the accepted command has completed, including tRP/tRFC.
- refreshOverrun  out  1  sticky: a refresh interval expired while the previous refresh was still pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; all outputs 0.
  - refreshPending 0; refresh timer loaded with REFRESH_INTERVAL-1; vidRun 0.
- While initDone is low: state held IDLE, timer held at its reload value, no grants.
- Refresh timer:
  - Decrements every cycle once initDone is high.
  - At 0 it reloads REFRESH_INTERVAL-1 and sets refreshPending.
  - If refreshPending is already 1 at expiry, refreshOverrun is set and stays set until reset.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE, arbitration evaluated every cycle, priority in this order:
  1. refreshPending.
  2. drawReq, if vidRun == MAX_VID_RUN.
  3. vidReq.
  4. drawReq.
- IDLE → ISSUE: the winner's kind, address and data are registered; memCmdValid rises the next cycle. No requester active: stay IDLE.
- ISSUE:
  - memCmdValid held high and memCmd* held stable until memCmdReady is sampled high.
  - On the accept cycle: go to WAIT_DONE, deassert memCmdValid next cycle, pulse the winner's gnt in the following cycle (registered, exactly one cycle).
  - A refresh accept clears refreshPending.
- WAIT_DONE: wait for memDone, then go to IDLE. memDone received in any other state is ignored.
- Latency: request first seen in IDLE at cycle N gives memCmdValid at N+1; with ready high at N+1, gnt at N+2 and WAIT_DONE at N+2.
- vidRun:
  - Increments, saturating at MAX_VID_RUN, on each video accept while drawReq is high.
  - Cleared on a draw accept, or when drawReq is low during a video accept.
- Simultaneous events:
  - Timer expiry in the same cycle as a refresh accept: refreshPending stays 1 (new interval), no overrun.
  - A requester deasserting before its gnt is a protocol error; the latched command still completes.
- Reset mid-operation: the command is abandoned; the sequencer is reset by the same rst_n.

Optional Feature:
- DDR_ARB_STATS_EN defined:
  - Adds 16-bit saturating counters vidGrantCount, drawGrantCount and refreshCount as output ports, cleared on reset.
  - Adds 1-bit input statsClear, which zeroes them synchronously.
- Not defined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ddr_pkg holds:
  - memCmdKind encodings (CMD_READ, CMD_WRITE, CMD_REFRESH).
  - FSM state encodings.
  - Default ADDR_W and REFRESH_INTERVAL.
- One natural sub-module, ddr_refresh_timer: counter, pending flag, overrun flag, pending-clear input.

Test Plan:
- Reset, then initDone=1 with no requests; after 1040 cycles → memCmdValid with memCmdKind=10, memCmdAddr=0. Ready high → refreshPending clears; memDone → IDLE.
- vidReq with vidAddr=0x0012345 in IDLE at cycle N, ready tied high → memCmdValid at N+1 with kind 00, vidGnt pulse at N+2 only.
- vidReq and drawReq held continuously, memDone 3 cycles after each accept → grants vid×8, then draw×1, repeating; vidRun returns to 0 after each draw grant.
- Refresh expires while a draw write is in WAIT_DONE and vidReq is high → after memDone, refresh issues before video; vid grant follows the refresh's memDone.
- memDone withheld for more than 2×1040 cycles → refreshOverrun=1 and stays 1 after traffic resumes; rst_n pulse → 0.
- rst_n low while in ISSUE with memCmdValid=1 → memCmdValid, gnts and refreshOverrun all 0 immediately; timer restarts at 1039.
